minefield_reveal_engine: RTL

//  Parametrised board engine for the minesweeper game: owns the ROWS x COLS cell state, takes mine placement,

---
 rtl/minefield_reveal_engine.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/minefield_reveal_engine.sv
// Minesweeper board engine: mine placement, reveal/flag command execution,
// fixed-latency 8-neighbour mine count and lost/won tracking with a registered display read port.
module minefield_reveal_engine #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned XW   = $clog2(COLS),
  parameter int unsigned YW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          load_valid,
  input  logic [XW-1:0] load_x,
  input  logic [YW-1:0] load_y,
  input  logic          start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  output logic          cmd_done,
  output logic          cmd_err,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [6:0]    rd_cell,
  output logic [1:0]    status,
  output logic [7:0]    mine_cnt
);

  localparam int unsigned NC = ROWS * COLS;
  localparam int unsigned IW = $clog2(NC);

  typedef enum logic [2:0] {
    S_SETUP, S_IDLE, S_FLAG, S_SCAN, S_RESOLVE, S_LOST, S_WON
  } state_e;

  state_e              state_q, state_d;
  logic [NC-1:0]       mine_q, mine_d, flag_q, flag_d, rev_q, rev_d;
  logic [NC-1:0][3:0]  cnt_q, cnt_d;
  logic [7:0]          mine_cnt_q, mine_cnt_d;
  logic [8:0]          rev_cnt_q, rev_cnt_d;
  logic [XW-1:0]       tx_q, tx_d;
  logic [YW-1:0]       ty_q, ty_d;
  logic [2:0]          nb_q, nb_d;
  logic [3:0]          acc_q, acc_d;
  logic                cmd_ready_q, cmd_ready_d, cmd_done_q, cmd_done_d, cmd_err_q, cmd_err_d;
  logic [6:0]          rd_cell_q, rd_cell_d;
  logic [1:0]          status_q, status_d;

  int                  dx, dy, nb_x, nb_y;
  logic                nb_in, nb_mine, ld_in, cmd_in, rd_in, win;
  logic [IW-1:0]       nb_idx, ld_idx, cmd_idx, rd_idx, t_idx;

  // Coordinate decode for neighbour under scan, load, command target and display read
  always_comb begin
    dx = 1;
    dy = 1;
    case (nb_q)
      3'd0:    begin dx = -1; dy = -1; end
      3'd1:    begin dx =  0; dy = -1; end
      3'd2:    begin dx =  1; dy = -1; end
      3'd3:    begin dx = -1; dy =  0; end
      3'd4:    begin dx =  1; dy =  0; end
      3'd5:    begin dx = -1; dy =  1; end
      3'd6:    begin dx =  0; dy =  1; end
      default: begin dx =  1; dy =  1; end
    endcase
    nb_x    = int'(tx_q) + dx;
    nb_y    = int'(ty_q) + dy;
    nb_in   = (nb_x >= 0) && (nb_x < int'(COLS)) && (nb_y >= 0) && (nb_y < int'(ROWS));
    nb_idx  = nb_in ? IW'(nb_y * int'(COLS) + nb_x) : '0;
    nb_mine = nb_in && mine_q[nb_idx];
    ld_in   = (int'(load_x) < int'(COLS)) && (int'(load_y) < int'(ROWS));
    ld_idx  = ld_in ? IW'(int'(load_y) * int'(COLS) + int'(load_x)) : '0;
    cmd_in  = (int'(cmd_x) < int'(COLS)) && (int'(cmd_y) < int'(ROWS));
    cmd_idx = cmd_in ? IW'(int'(cmd_y) * int'(COLS) + int'(cmd_x)) : '0;
    rd_in   = (int'(rd_x) < int'(COLS)) && (int'(rd_y) < int'(ROWS));
    rd_idx  = rd_in ? IW'(int'(rd_y) * int'(COLS) + int'(rd_x)) : '0;
    t_idx   = IW'(int'(ty_q) * int'(COLS) + int'(tx_q));
    win     = (int'(rev_cnt_q) + 1) == (int'(NC) - int'(mine_cnt_q));
  end

  // Next-state: game FSM, board updates and registered outputs
  always_comb begin
    state_d    = state_q;
    mine_d     = mine_q;
    flag_d     = flag_q;
    rev_d      = rev_q;
    cnt_d      = cnt_q;
    mine_cnt_d = mine_cnt_q;
    rev_cnt_d  = rev_cnt_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    nb_d       = nb_q;
    acc_d      = acc_q;
    cmd_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    rd_cell_d  = rd_in ? {rev_q[rd_idx], flag_q[rd_idx],
                          mine_q[rd_idx] & (rev_q[rd_idx] | (state_q == S_LOST)),
                          cnt_q[rd_idx]} : '0;

    case (state_q)
      S_SETUP: begin
        if (load_valid && ld_in && !mine_q[ld_idx]) begin
          mine_d[ld_idx] = 1'b1;
          mine_cnt_d     = mine_cnt_q + 8'd1;
        end
        if (start) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          tx_d = cmd_x;
          ty_d = cmd_y;
          if (!cmd_in) begin
            cmd_done_d = 1'b1;
            cmd_err_d  = 1'b1;
            state_d    = S_RESOLVE;
          end else if (cmd_op) begin
            cmd_done_d = 1'b1;
            if (rev_q[cmd_idx]) begin
              cmd_err_d = 1'b1;
              state_d   = S_RESOLVE;
            end else begin
              flag_d[cmd_idx] = ~flag_q[cmd_idx];
              state_d         = S_FLAG;
            end
          end else if (flag_q[cmd_idx] || rev_q[cmd_idx]) begin
            cmd_done_d = 1'b1;
            cmd_err_d  = 1'b1;
            state_d    = S_RESOLVE;
          end else if (mine_q[cmd_idx]) begin
            rev_d[cmd_idx] = 1'b1;
            cmd_done_d     = 1'b1;
            state_d        = S_LOST;
          end else begin
            nb_d    = 3'd0;
            acc_d   = 4'd0;
            state_d = S_SCAN;
          end
        end
      end
      S_FLAG, S_RESOLVE: state_d = S_IDLE;
      S_SCAN: begin
        acc_d = acc_q + 4'(nb_mine);
        nb_d  = nb_q + 3'd1;
        if (nb_q == 3'd7) begin
          cnt_d[t_idx] = acc_d;
          rev_d[t_idx] = 1'b1;
          rev_cnt_d    = rev_cnt_q + 9'd1;
          cmd_done_d   = 1'b1;
          state_d      = win ? S_WON : S_IDLE;
        end
      end
      S_LOST, S_WON: state_d = state_q;
      default:       state_d = S_SETUP;
    endcase

    if (new_game) begin
      state_d    = S_SETUP;
      mine_d     = '0;
      flag_d     = '0;
      rev_d      = '0;
      cnt_d      = '0;
      mine_cnt_d = '0;
      rev_cnt_d  = '0;
      cmd_done_d = 1'b0;
      cmd_err_d  = 1'b0;
      rd_cell_d  = '0;
    end

    cmd_ready_d = (state_d == S_IDLE);
    case (state_d)
      S_SETUP: status_d = 2'd0;
      S_LOST:  status_d = 2'd2;
      S_WON:   status_d = 2'd3;
      default: status_d = 2'd1;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SETUP;
      mine_q      <= '0;
      flag_q      <= '0;
      rev_q       <= '0;
      cnt_q       <= '0;
      mine_cnt_q  <= '0;
      rev_cnt_q   <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      nb_q        <= '0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      rd_cell_q   <= '0;
      status_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      mine_q      <= mine_d;
      flag_q      <= flag_d;
      rev_q       <= rev_d;
      cnt_q       <= cnt_d;
      mine_cnt_q  <= mine_cnt_d;
      rev_cnt_q   <= rev_cnt_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      nb_q        <= nb_d;
      acc_q       <= acc_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_done_q  <= cmd_done_d;
      cmd_err_q   <= cmd_err_d;
      rd_cell_q   <= rd_cell_d;
      status_q    <= status_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_done  = cmd_done_q;
  assign cmd_err   = cmd_err_q;
  assign rd_cell   = rd_cell_q;
  assign status    = status_q;
  assign mine_cnt  = mine_cnt_q;

endmodule
